bloom_request_sequencer: RTL and testbench

Front-end sequencer for the counting Bloom filter. Accepts probe/insert/delete requests on a valid/ready channel, buffers them in a small FIFO, and drives the filter's address, write-enable and increment inputs with correct settle spacing. Every delete is probe-guarded so the filter's counters are never decremented below zero. Returns one response per request (hit flag, op echo, error) on a second valid/ready channel.

---
 rtl/bloom_request_sequencer.sv | 172 +++++++++++++++++
 tb/tb_bloom_request_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bloom_request_sequencer.sv
// Request front-end for a counting Bloom filter: buffers requests, spaces filter probes and
// writes so results can settle, and guards each delete with a probe so counters never underflow.
module bloom_request_sequencer #(
    parameter int ADDR_W     = 57,
    parameter int FIFO_DEPTH = 4,
    parameter int RESULT_LAT = 1
) (
    input  logic              CLK,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [1:0]        resp_op,
    output logic              resp_err,
    output logic [ADDR_W-1:0] bf_addr,
    output logic              bf_we,
    output logic              bf_inc,
    input  logic              bf_result,
    output logic              busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(RESULT_LAT + 2);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESULT_LAT);
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    // IDLE wait | PROBE read filter | WRITE single we pulse | SETTLE post-write gap | RESP hold response
    typedef enum logic [2:0] {IDLE, PROBE, WRITE, SETTLE, RESP} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [1:0]        op;
    logic              hit, hit_next;
    logic              push, pop, to_resp;
    logic              fifo_empty, fifo_full;
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic [1:0]        fifo_op   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic              we_next, inc_next;
    logic              resp_valid_next, resp_hit_next, resp_err_next;
    logic [1:0]        resp_op_next;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_op[wr_ptr[PTR_W-1:0]]   <= req_op;
            fifo_addr[wr_ptr[PTR_W-1:0]] <= req_addr;
        end
    end

    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            cnt        <= '0;
            hit        <= 1'b0;
            op         <= '0;
            bf_addr    <= '0;
            bf_we      <= 1'b0;
            bf_inc     <= 1'b0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_op    <= '0;
            resp_err   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            hit        <= hit_next;
            bf_we      <= we_next;
            bf_inc     <= inc_next;
            resp_valid <= resp_valid_next;
            resp_hit   <= resp_hit_next;
            resp_op    <= resp_op_next;
            resp_err   <= resp_err_next;
            if (pop) begin
                op      <= fifo_op[rd_ptr[PTR_W-1:0]];
                bf_addr <= fifo_addr[rd_ptr[PTR_W-1:0]];
            end
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        hit_next        = hit;
        pop             = 1'b0;
        to_resp         = 1'b0;
        we_next         = 1'b0;
        inc_next        = 1'b0;
        resp_valid_next = resp_valid;
        resp_hit_next   = resp_hit;
        resp_op_next    = resp_op;
        resp_err_next   = resp_err;

        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = PROBE;
                    cnt_next   = CNT_LOAD;
                end
            end
            PROBE: begin
                if (cnt == '0) begin
                    hit_next = bf_result;
                    if (op == OP_INSERT) begin
                        state_next = WRITE;
                        we_next    = 1'b1;
                        inc_next   = 1'b1;
                    end else if (op == OP_DELETE && bf_result) begin
                        state_next = WRITE;
                        we_next    = 1'b1;
                    end else begin
                        to_resp = 1'b1;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            WRITE: begin
                state_next = SETTLE;
                cnt_next   = CNT_LOAD;
            end
            SETTLE: begin
                if (cnt == '0) to_resp = 1'b1;
                else           cnt_next = cnt - 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_next = 1'b0;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = PROBE;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // The probe result is still on bf_result when leaving PROBE directly; after a write use the latched copy.
        if (to_resp) begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_hit_next   = (state == PROBE) ? bf_result : hit;
            resp_op_next    = op;
            resp_err_next   = (op == OP_RSVD);
        end
    end
endmodule

// File: tb/tb_bloom_request_sequencer.sv
// Bench for bloom_request_sequencer: a counting-filter model answers probes, and a
// transaction-level reference predicts every response, its latency and its write pulses.
module tb_bloom_request_sequencer;
    localparam int ADDR_W    = 57;
    localparam int LAT       = 1;
    localparam int SHORT_LAT = LAT + 2;
    localparam int LONG_LAT  = 2 * LAT + 4;

    logic              CLK = 1'b0;
    logic              rstb = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [1:0]        req_op = 2'b00;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b1;
    logic              resp_hit;
    logic [1:0]        resp_op;
    logic              resp_err;
    logic [ADDR_W-1:0] bf_addr;
    logic              bf_we;
    logic              bf_inc;
    logic              bf_result = 1'b0;
    logic              busy;

    bloom_request_sequencer #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .RESULT_LAT(LAT)) dut (
        .CLK(CLK), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_op(resp_op), .resp_err(resp_err),
        .bf_addr(bf_addr), .bf_we(bf_we), .bf_inc(bf_inc), .bf_result(bf_result),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]        op;
        logic              hit;
        logic              err;
        logic [ADDR_W-1:0] addr;
        int                lat;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned ref_cnt [logic [ADDR_W-1:0]];
    int unsigned fcount  [logic [ADDR_W-1:0]];
    int          vectors = 0;
    int          miscompares = 0;
    int          we_cnt = 0;
    int          inc_cnt = 0;
    int          we_base = 0;
    int          inc_base = 0;
    logic        prev_we = 1'b0;
    time         hs_time = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Filter model: captures the address each edge, result visible one cycle later.
    always @(negedge rstb) fcount.delete();

    always @(posedge CLK or negedge rstb) begin
        if (!rstb) begin
            bf_result <= 1'b0;
        end else begin
            bf_result <= fcount.exists(bf_addr) && (fcount[bf_addr] != 0);
            if (bf_we) begin
                if (bf_inc) begin
                    fcount[bf_addr] = (fcount.exists(bf_addr) ? fcount[bf_addr] : 0) + 1;
                end else begin
                    check("delete_underflow", 64'(fcount.exists(bf_addr) && (fcount[bf_addr] != 0)), 1);
                    if (fcount.exists(bf_addr) && (fcount[bf_addr] != 0))
                        fcount[bf_addr] = fcount[bf_addr] - 1;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (!rstb) begin
            prev_we = 1'b0;
        end else begin
            if (bf_we) begin
                we_cnt++;
                if (bf_inc) inc_cnt++;
                check("we_back_to_back", prev_we, 0);
            end
            if (bf_inc) check("inc_without_we", bf_we, 1);
            prev_we = bf_we;
        end
    end

    function automatic void predict(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
        exp_t e;
        int unsigned c = ref_cnt.exists(addr) ? ref_cnt[addr] : 0;
        e.op   = op;
        e.addr = addr;
        e.hit  = (c > 0);
        e.err  = (op == 2'b11);
        e.lat  = SHORT_LAT;
        if (op == 2'b01) begin
            ref_cnt[addr] = c + 1;
            e.lat = LONG_LAT;
        end else if (op == 2'b10 && c > 0) begin
            ref_cnt[addr] = c - 1;
            e.lat = LONG_LAT;
        end
        exp_q.push_back(e);
    endfunction

    task automatic push(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        while (!req_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            check("push_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        we_base  = we_cnt;
        inc_base = inc_cnt;
        @(posedge CLK);
        hs_time = $time;
        predict(op, addr);
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input bit single);
        int   n = 0;
        int   lat;
        exp_t e;
        while (!resp_valid && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("resp_timeout", resp_valid, 1);
        if (!resp_valid) return;
        if (exp_q.size() == 0) begin
            check("unexpected_resp", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check("resp_op", resp_op, e.op);
        check("resp_hit", resp_hit, e.hit);
        check("resp_err", resp_err, e.err);
        check("bf_addr", bf_addr, e.addr);
        if (single) begin
            lat = int'(($time - 5 - hs_time) / 10);
            check("latency", lat, e.lat);
            check("we_pulses", we_cnt - we_base, (e.lat == LONG_LAT) ? 1 : 0);
            check("inc_pulses", inc_cnt - inc_base, (e.op == 2'b01) ? 1 : 0);
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [ADDR_W-1:0] pool [4];
        logic [1:0]        rop;
        int                n;
        pool[0] = 57'h000_A000;
        pool[1] = 57'h000_A008;
        pool[2] = 57'h0B1_2340;
        pool[3] = {ADDR_W{1'b1}};

        repeat (2) @(negedge CLK);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_hit", resp_hit, 0);
        check("rst_resp_op", resp_op, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_bf_addr", bf_addr, 0);
        check("rst_bf_we", bf_we, 0);
        check("rst_bf_inc", bf_inc, 0);
        check("rst_busy", busy, 0);
        check("rst_req_ready", req_ready, 1);
        rstb = 1'b1;
        @(negedge CLK);
        check("idle_busy", busy, 0);

        push(2'b00, 57'h1000);
        wait_resp(1);

        push(2'b01, 57'h5000);
        wait_resp(1);
        push(2'b00, 57'h5000);
        wait_resp(1);

        push(2'b10, 57'h7000);
        wait_resp(1);
        push(2'b00, 57'h7000);
        wait_resp(1);

        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'b00, 57'(32'h2000 + $urandom_range(0, 7) * 8));
        check("fifo_full_ready", req_ready, 0);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 57'h3333;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("refused_push", req_ready, 0);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("hold_valid", resp_valid, 1);
            check("hold_op", resp_op, exp_q[0].op);
            check("hold_hit", resp_hit, exp_q[0].hit);
            check("hold_addr", bf_addr, exp_q[0].addr);
            check("hold_busy", busy, 1);
            @(negedge CLK);
        end
        resp_ready = 1'b1;
        for (int i = 0; i < 5; i++) wait_resp(0);
        check("drained_busy", busy, 0);

        push(2'b01, 57'h9000);
        wait_resp(1);
        push(2'b11, 57'h9000);
        wait_resp(1);

        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            push(rop, pool[$urandom_range(0, 3)]);
            wait_resp(1);
        end

        push(2'b01, 57'h5000);
        n = 0;
        while (!bf_we && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("saw_write", bf_we, 1);
        #2 rstb = 1'b0;
        #1 check("we_async_drop", bf_we, 0);
        exp_q.delete();
        ref_cnt.delete();
        @(negedge CLK);
        @(negedge CLK);
        rstb = 1'b1;
        @(negedge CLK);
        check("post_rst_resp_valid", resp_valid, 0);
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_busy", busy, 0);
        push(2'b00, 57'h5000);
        wait_resp(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
